// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage constants and the prefetch FIFO entry layout.
//   PC_STEP          : byte increment between sequential word fetches
//   PC_READ_OFFSET   : ARM R15 read value offset from the instruction address
//   RESET_PC_DEFAULT : default PC loaded on reset
package instr_fetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] PC_STEP          = 32'd4;
  localparam logic [XLEN-1:0] PC_READ_OFFSET   = 32'd8;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // One buffered instruction with the address it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

  // Force a byte address onto a word boundary.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/instr_fetch_fifo.sv
// Synchronous DEPTH-entry FIFO with flush and occupancy count.
//   clk, rst_n : clock, synchronous active-low reset
//   flush      : empty the FIFO (wins over push/pop in the same cycle)
//   push       : write push_data at the tail (honoured when not full or popping)
//   pop        : drop the head entry (ignored when empty)
//   head_data  : current head entry
//   count      : number of valid entries, 0..DEPTH
module fetch_fifo #(
  parameter int unsigned     DEPTH     = 2,
  parameter int unsigned     WIDTH     = 64,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  // A pop frees a slot, so push at full is legal when paired with a pop.
  always_comb begin
    do_pop  = pop && (cnt != '0);
    do_push = push && ((cnt != CW'(DEPTH)) || do_pop);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= RESET_VAL;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  assign head_data = mem[rd_ptr];
  assign count     = cnt;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues word fetches under a credit
// limit, buffers returned words and hands one instruction per handshake to
// decode. A redirect from decode flushes the buffer and discards every
// response still in flight for the old path.
//   clk, rst_n                    : clock, synchronous active-low reset
//   imem_req_valid/ready, imem_addr : fetch request channel
//   imem_rsp_valid, imem_rsp_data   : in-order response channel
//   instr_valid/ready, instr, instr_pc, pc_plus8 : decode channel
//   redirect, redirect_pc         : PC write from decode
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0]  RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned  DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus8,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = CW + 1;

  logic [31:0]   fetch_pc_q;
  logic [31:0]   fetch_pc_n;
  logic [CW-1:0] drop_q;
  logic [CW-1:0] drop_n;
  logic          first_q;

  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_after;
  logic [CW-1:0] count;
  logic [SW-1:0] credit_used;
  logic [31:0]   rsp_pc;

  logic          req_fire;
  logic          rsp_drop;
  logic          push;
  logic          pop;

  fetch_entry_t  push_entry;
  fetch_entry_t  head_entry;

  // Credit check, handshake qualification and drop bookkeeping.
  always_comb begin
    credit_used    = SW'(outstanding) + SW'(count);
    imem_req_valid = !first_q && !redirect && (credit_used < SW'(DEPTH));
    req_fire       = imem_req_valid && imem_req_ready;

    rsp_drop = imem_rsp_valid && (drop_q != '0);
    push     = imem_rsp_valid && !rsp_drop && !redirect;
    pop      = instr_valid && instr_ready && !redirect;

    outstanding_after = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);

    push_entry.instr = imem_rsp_data;
    push_entry.pc    = rsp_pc;

    fetch_pc_n = fetch_pc_q;
    drop_n     = drop_q;
    if (redirect) begin
      // A same-cycle response has already been discarded above, so
      // everything still outstanding afterwards belongs to the old path.
      fetch_pc_n = word_align(redirect_pc);
      drop_n     = outstanding_after;
    end else begin
      if (req_fire) begin
        fetch_pc_n = fetch_pc_q + PC_STEP;
      end
      if (rsp_drop) begin
        drop_n = drop_q - CW'(1);
      end
    end
  end

  // PC, drop counter and post-reset request blanking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      drop_q     <= '0;
      first_q    <= 1'b1;
    end else begin
      fetch_pc_q <= fetch_pc_n;
      drop_q     <= drop_n;
      first_q    <= 1'b0;
    end
  end

  // Issue-address queue: one PC tag per outstanding request, popped by every
  // response (kept or dropped), so its occupancy is the outstanding count.
  fetch_fifo #(
    .DEPTH     (DEPTH),
    .WIDTH     (32),
    .RESET_VAL (32'h0)
  ) u_addr_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (1'b0),
    .push      (req_fire),
    .push_data (fetch_pc_q),
    .pop       (imem_rsp_valid),
    .head_data (rsp_pc),
    .count     (outstanding)
  );

  // Prefetch buffer of {instr, pc}; flushed by redirect.
  fetch_fifo #(
    .DEPTH     (DEPTH),
    .WIDTH     (ENTRY_W),
    .RESET_VAL ({32'h0, RESET_PC})
  ) u_instr_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_entry),
    .count     (count)
  );

  assign imem_addr   = fetch_pc_q;
  assign instr_valid = (count != '0);
  assign instr       = head_entry.instr;
  assign instr_pc    = head_entry.pc;
  assign pc_plus8    = head_entry.pc + PC_READ_OFFSET;

endmodule
